hs_dpath_sfr_ce_ctrl: RTL and testbench

Valid/ready pipeline controller that drives the per-stage tapped clock enables of a LATENCY-deep shift register datapath (hs_dpath_sfr_ce_tap).
- Tracks one valid bit per stage.
- Converts upstream/downstream valid/ready handshakes into per-stage ce.
- Optionally collapses bubbles, so a stalled output does not freeze empty upstream stages.
- Instantiated beside each tapped shift register in streaming datapaths.

---
 rtl/hs_dpath_pkg.sv | 9 +
 rtl/hs_dpath_occ_cnt.sv | 26 ++
 rtl/hs_dpath_sfr_ce_ctrl.sv | 71 +++++++
 tb/tb_hs_dpath_sfr_ce_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/hs_dpath_pkg.sv
// hs_dpath_pkg: shared helpers and mode constants for the tapped shift-register datapath controllers.
package hs_dpath_pkg;
   localparam int unsigned HS_SFR_MODE_COLLAPSE = 1;
   localparam int unsigned HS_SFR_MODE_STALL    = 0;

   function automatic int unsigned occ_w(input longint unsigned depth);
      return $clog2(depth + 1);
   endfunction
endpackage

// File: rtl/hs_dpath_occ_cnt.sv
// hs_dpath_occ_cnt: saturating up/down occupancy counter with synchronous clear and empty/full flags.
module hs_dpath_occ_cnt
   import hs_dpath_pkg::*;
#(
   parameter int unsigned MAX = 1,
   localparam int unsigned W  = occ_w(MAX)
) (
   input  logic         clk,
   input  logic         aresetn,
   input  logic         inc,
   input  logic         dec,
   input  logic         clr,
   output logic [W-1:0] cnt,
   output logic         empty,
   output logic         full
);
   assign empty = (cnt == '0);
   assign full  = (cnt == W'(MAX));

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (inc && !dec && !full) cnt <= cnt + 1'b1;
      else if (dec && !inc && !empty) cnt <= cnt - 1'b1;
   end
endmodule

// File: rtl/hs_dpath_sfr_ce_ctrl.sv
// hs_dpath_sfr_ce_ctrl: valid/ready controller driving per-stage clock enables of a tapped shift register.
// Defining HS_DPATH_SFR_CE_CTRL_FLUSH_EN adds a synchronous flush input that empties the pipeline.
module hs_dpath_sfr_ce_ctrl
   import hs_dpath_pkg::*;
#(
   parameter int unsigned LATENCY         = 1,
   parameter int unsigned BUBBLE_COLLAPSE = HS_SFR_MODE_COLLAPSE,
   localparam int unsigned CNT_W          = occ_w(LATENCY)
) (
   input  logic             clk,
   input  logic             aresetn,
`ifdef HS_DPATH_SFR_CE_CTRL_FLUSH_EN
   input  logic             flush,
`endif
   input  logic             in_valid,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             ce [LATENCY],
   output logic             stage_vld [LATENCY],
   output logic [CNT_W-1:0] occupancy,
   output logic             empty,
   output logic             full
);
   logic hold;
   logic chain [LATENCY];
   logic in_fire, out_fire;

`ifdef HS_DPATH_SFR_CE_CTRL_FLUSH_EN
   assign hold = flush;
`else
   assign hold = 1'b0;
`endif

   // Enables resolve from the output end so a stall only freezes stages that are packed behind it.
   always_comb begin
      chain[LATENCY-1] = out_ready | ~stage_vld[LATENCY-1];
      for (int i = int'(LATENCY) - 2; i >= 0; i--)
         chain[i] = (BUBBLE_COLLAPSE == HS_SFR_MODE_COLLAPSE) ? (chain[i+1] | ~stage_vld[i]) : chain[LATENCY-1];
      for (int i = 0; i < int'(LATENCY); i++)
         ce[i] = chain[i] & ~hold;
   end

   assign in_ready  = ce[0];
   assign out_valid = stage_vld[LATENCY-1] & ~hold;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         for (int i = 0; i < int'(LATENCY); i++) stage_vld[i] <= 1'b0;
      end else if (hold) begin
         for (int i = 0; i < int'(LATENCY); i++) stage_vld[i] <= 1'b0;
      end else begin
         if (ce[0]) stage_vld[0] <= in_valid;
         for (int i = 1; i < int'(LATENCY); i++)
            if (ce[i]) stage_vld[i] <= stage_vld[i-1];
      end
   end

   hs_dpath_occ_cnt #(.MAX(LATENCY)) u_occ (
      .clk     (clk),
      .aresetn (aresetn),
      .inc     (in_fire),
      .dec     (out_fire),
      .clr     (hold),
      .cnt     (occupancy),
      .empty   (empty),
      .full    (full)
   );
endmodule

// File: tb/tb_hs_dpath_sfr_ce_ctrl.sv
// tb_hs_dpath_sfr_ce_ctrl: directed bench for the ce controller, LATENCY=4 in collapse and stall modes side by side.
module tb_hs_dpath_sfr_ce_ctrl;
   logic clk = 1'b0;
   logic aresetn = 1'b0;
   logic in_valid = 1'b0;
   logic out_ready = 1'b0;
`ifdef HS_DPATH_SFR_CE_CTRL_FLUSH_EN
   logic flush = 1'b0;
`endif
   logic ir_c, ov_c, em_c, fu_c, ir_s, ov_s, em_s, fu_s;
   logic ce_cu [4], sv_cu [4], ce_su [4], sv_su [4];
   logic [2:0] occ_c, occ_s;
   logic [3:0] cec, svc, ces, svs;
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   hs_dpath_sfr_ce_ctrl #(.LATENCY(4), .BUBBLE_COLLAPSE(1)) u_c (
      .clk(clk), .aresetn(aresetn),
`ifdef HS_DPATH_SFR_CE_CTRL_FLUSH_EN
      .flush(flush),
`endif
      .in_valid(in_valid), .in_ready(ir_c), .out_valid(ov_c), .out_ready(out_ready),
      .ce(ce_cu), .stage_vld(sv_cu), .occupancy(occ_c), .empty(em_c), .full(fu_c));

   hs_dpath_sfr_ce_ctrl #(.LATENCY(4), .BUBBLE_COLLAPSE(0)) u_s (
      .clk(clk), .aresetn(aresetn),
`ifdef HS_DPATH_SFR_CE_CTRL_FLUSH_EN
      .flush(flush),
`endif
      .in_valid(in_valid), .in_ready(ir_s), .out_valid(ov_s), .out_ready(out_ready),
      .ce(ce_su), .stage_vld(sv_su), .occupancy(occ_s), .empty(em_s), .full(fu_s));

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         cec[i] = ce_cu[i];
         svc[i] = sv_cu[i];
         ces[i] = ce_su[i];
         svs[i] = sv_su[i];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Occupancy must stay in range and agree with the number of set stage valids.
   always @(negedge clk) begin
      if (aresetn) begin
         chk("occ_max_c", 32'(occ_c <= 3'd4), 32'd1);
         chk("occ_max_s", 32'(occ_s <= 3'd4), 32'd1);
         chk("occ_pop_c", 32'(occ_c), 32'($countones(svc)));
         chk("occ_pop_s", 32'(occ_s), 32'($countones(svs)));
      end
   end

   initial begin
      tick(2);
      aresetn = 1'b1;
      #1;
      chk("rst_occ_c", 32'(occ_c), 0);
      chk("rst_empty_c", 32'(em_c), 1);
      chk("rst_full_c", 32'(fu_c), 0);
      chk("rst_ov_c", 32'(ov_c), 0);
      chk("rst_ir_c", 32'(ir_c), 1);
      chk("rst_ce_c", 32'(cec), 32'hf);
      chk("rst_ce_s", 32'(ces), 32'hf);

      // streaming: first beat accepted at the next edge, out_valid 4 edges later
      in_valid = 1'b1;
      out_ready = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         tick(1);
         chk("lat_ov_low_c", 32'(ov_c), 0);
         chk("lat_occ_c", 32'(occ_c), 32'(k));
      end
      tick(1);
      chk("lat_ov_high_c", 32'(ov_c), 1);
      chk("lat_ov_high_s", 32'(ov_s), 1);
      for (int k = 0; k < 3; k++) begin
         tick(1);
         chk("stream_occ_c", 32'(occ_c), 4);
         chk("stream_full_c", 32'(fu_c), 1);
         chk("stream_ir_c", 32'(ir_c), 1);
         chk("stream_ov_s", 32'(ov_s), 1);
      end

      // full and stalled for 5 cycles
      out_ready = 1'b0;
      #1;
      for (int k = 0; k < 5; k++) begin
         chk("stall_ce_c", 32'(cec), 0);
         chk("stall_ce_s", 32'(ces), 0);
         chk("stall_ir_c", 32'(ir_c), 0);
         chk("stall_ir_s", 32'(ir_s), 0);
         chk("stall_ov_c", 32'(ov_c), 1);
         chk("stall_occ_c", 32'(occ_c), 4);
         chk("stall_occ_s", 32'(occ_s), 4);
         tick(1);
      end

      // drop to occupancy 3 then reset asynchronously mid-cycle
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick(1);
      chk("pre_rst_occ_c", 32'(occ_c), 3);
      chk("pre_rst_sv_c", 32'(svc), 32'he);
      #2;
      aresetn = 1'b0;
      #1;
      chk("arst_occ_c", 32'(occ_c), 0);
      chk("arst_sv_c", 32'(svc), 0);
      chk("arst_ov_c", 32'(ov_c), 0);
      chk("arst_occ_s", 32'(occ_s), 0);
      tick(1);
      aresetn = 1'b1;
      out_ready = 1'b0;
      #1;
      chk("post_rst_ir_c", 32'(ir_c), 1);
      chk("post_rst_ir_s", 32'(ir_s), 1);

      // one beat with out_ready low travels to the last stage in both modes
      in_valid = 1'b1;
      tick(1);
      in_valid = 1'b0;
      chk("beat_a_sv_c", 32'(svc), 32'h1);
      tick(3);
      chk("beat_a_end_c", 32'(svc), 32'h8);
      chk("beat_a_end_s", 32'(svs), 32'h8);
      in_valid = 1'b1;
      #1;
      chk("beat_b_ir_c", 32'(ir_c), 1);
      chk("beat_b_ir_s", 32'(ir_s), 0);
      chk("beat_b_ce_c", 32'(cec), 32'h7);
      chk("beat_b_ce_s", 32'(ces), 0);
      tick(1);
      in_valid = 1'b0;
      chk("beat_b_sv_c", 32'(svc), 32'h9);
      chk("beat_b_sv_s", 32'(svs), 32'h8);
      chk("beat_b_occ_s", 32'(occ_s), 1);
      tick(2);
      chk("pack_sv_c", 32'(svc), 32'hc);
      chk("pack_occ_c", 32'(occ_c), 2);
      chk("pack_ir_c", 32'(ir_c), 1);
      chk("pack_ce_c", 32'(cec), 32'h3);
      chk("pack_sv_s", 32'(svs), 32'h8);
      tick(1);
      chk("packed_hold_c", 32'(svc), 32'hc);

      // drain both pipelines
      out_ready = 1'b1;
      tick(6);
      chk("drain_empty_c", 32'(em_c), 1);
      chk("drain_empty_s", 32'(em_s), 1);
      chk("drain_ov_c", 32'(ov_c), 0);

`ifdef HS_DPATH_SFR_CE_CTRL_FLUSH_EN
      in_valid = 1'b1;
      tick(4);
      chk("fl_pre_occ_c", 32'(occ_c), 4);
      flush = 1'b1;
      #1;
      chk("fl_ir_c", 32'(ir_c), 0);
      chk("fl_ov_c", 32'(ov_c), 0);
      chk("fl_ce_c", 32'(cec), 0);
      chk("fl_ir_s", 32'(ir_s), 0);
      tick(1);
      flush = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("fl_occ_c", 32'(occ_c), 0);
      chk("fl_empty_c", 32'(em_c), 1);
      chk("fl_sv_c", 32'(svc), 0);
      chk("fl_ov_after_c", 32'(ov_c), 0);
      chk("fl_occ_s", 32'(occ_s), 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
